// File: rtl/riscv_core_mul_ctrl.sv
// riscv_core_mul_ctrl: sequencing controller for the RV32M multiply path.
// Operands are converted to sign-magnitude form, multiplied by an XLEN-step
// shift-add loop over a 2*XLEN product register, sign-corrected, and the
// requested half is held under a valid/ready handshake.
module riscv_core_mul_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mul_ctrl_valid,
    output logic            o_mul_ctrl_ready,
    input  logic [XLEN-1:0] i_mul_ctrl_srcA,
    input  logic [XLEN-1:0] i_mul_ctrl_srcB,
    input  logic [1:0]      i_mul_ctrl_control,
    input  logic            i_mul_ctrl_flush,
    output logic            o_mul_ctrl_busy,
    output logic            o_mul_ctrl_valid,
    input  logic            i_mul_ctrl_ready,
    output logic [XLEN-1:0] o_mul_ctrl_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0]       CTRL_MUL    = 2'b00;
    localparam logic [1:0]       CTRL_MULH   = 2'b01;
    localparam logic [1:0]       CTRL_MULHSU = 2'b10;
    localparam logic [1:0]       CTRL_MULHU  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [XLEN-1:0]  ZERO_W      = {XLEN{1'b0}};

    // Two's-complement negate of an operand-width value.
    function automatic logic [XLEN-1:0] negate_w(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negate of the double-width product.
    function automatic logic [2*XLEN-1:0] negate_p(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*XLEN-1:0]  prod_r;
    logic [XLEN-1:0]    mag_a_r;
    logic [1:0]         ctrl_r;
    logic               neg_r;
    logic               valid_r;
    logic [XLEN-1:0]    result_r;

    logic               sign_a_s;
    logic               sign_b_s;
    logic [XLEN-1:0]    mag_a_s;
    logic [XLEN-1:0]    mag_b_s;
    logic               zero_op_s;
    logic [XLEN:0]      add_s;
    logic [2*XLEN-1:0]  prod_next_s;
    logic [2*XLEN-1:0]  prod_fix_s;
    logic [XLEN-1:0]    result_sel_s;
    logic               busy_s;

    // Operand sign selection and magnitude conversion for the request at the port.
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (i_mul_ctrl_control)
            CTRL_MUL, CTRL_MULH: begin
                sign_a_s = i_mul_ctrl_srcA[XLEN-1];
                sign_b_s = i_mul_ctrl_srcB[XLEN-1];
            end
            CTRL_MULHSU: begin
                sign_a_s = i_mul_ctrl_srcA[XLEN-1];
                sign_b_s = 1'b0;
            end
            CTRL_MULHU: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
        if (sign_a_s) begin
            mag_a_s = negate_w(i_mul_ctrl_srcA);
        end else begin
            mag_a_s = i_mul_ctrl_srcA;
        end
        if (sign_b_s) begin
            mag_b_s = negate_w(i_mul_ctrl_srcB);
        end else begin
            mag_b_s = i_mul_ctrl_srcB;
        end
        zero_op_s = (mag_a_s == ZERO_W) || (mag_b_s == ZERO_W);
    end

    // One shift-add step: conditional add into the upper half, carry shifts into the MSB.
    always_comb begin
        if (prod_r[0]) begin
            add_s = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, mag_a_r};
        end else begin
            add_s = {1'b0, prod_r[2*XLEN-1:XLEN]};
        end
        prod_next_s = {add_s, prod_r[XLEN-1:1]};
    end

    // Final sign correction and result-half selection.
    always_comb begin
        if (neg_r) begin
            prod_fix_s = negate_p(prod_r);
        end else begin
            prod_fix_s = prod_r;
        end
        case (ctrl_r)
            CTRL_MUL:                           result_sel_s = prod_fix_s[XLEN-1:0];
            CTRL_MULH, CTRL_MULHSU, CTRL_MULHU: result_sel_s = prod_fix_s[2*XLEN-1:XLEN];
            default:                            result_sel_s = prod_fix_s[2*XLEN-1:XLEN];
        endcase
    end

    // Stall request: in flight, or holding an unaccepted result.
    always_comb begin
        case (state_r)
            ST_IDLE: busy_s = 1'b0;
            ST_CALC: busy_s = 1'b1;
            ST_FIX:  busy_s = 1'b1;
            ST_DONE: busy_s = ~i_mul_ctrl_ready;
            default: busy_s = 1'b0;
        endcase
    end

    // Controller FSM with datapath registers; flush outranks accept and handoff.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            prod_r   <= {(2*XLEN){1'b0}};
            mag_a_r  <= ZERO_W;
            ctrl_r   <= 2'b00;
            neg_r    <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= ZERO_W;
        end else if (i_mul_ctrl_flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_mul_ctrl_valid) begin
                        ctrl_r  <= i_mul_ctrl_control;
                        mag_a_r <= mag_a_s;
                        neg_r   <= sign_a_s ^ sign_b_s;
                        prod_r  <= {ZERO_W, mag_b_s};
                        cnt_r   <= {CNT_W{1'b0}};
                        if (zero_op_s) begin
                            result_r <= ZERO_W;
                            valid_r  <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    prod_r <= prod_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    prod_r   <= prod_fix_s;
                    result_r <= result_sel_s;
                    valid_r  <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_mul_ctrl_ready) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mul_ctrl_ready  = (state_r == ST_IDLE);
    assign o_mul_ctrl_busy   = busy_s;
    assign o_mul_ctrl_valid  = valid_r;
    assign o_mul_ctrl_result = result_r;

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Scoreboard bench for riscv_core_mul_ctrl: expected results are queued at
// issue time and a negedge monitor compares each delivered result.
module tb_riscv_core_mul_ctrl;

    localparam int XLEN = 32;
    localparam logic [1:0] C_MUL    = 2'b00;
    localparam logic [1:0] C_MULH   = 2'b01;
    localparam logic [1:0] C_MULHSU = 2'b10;
    localparam logic [1:0] C_MULHU  = 2'b11;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            dut_ready;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [1:0]      ctrl;
    logic            flush;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    riscv_core_mul_ctrl #(.XLEN(XLEN)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_mul_ctrl_valid   (req_valid),
        .o_mul_ctrl_ready   (dut_ready),
        .i_mul_ctrl_srcA    (src_a),
        .i_mul_ctrl_srcB    (src_b),
        .i_mul_ctrl_control (ctrl),
        .i_mul_ctrl_flush   (flush),
        .o_mul_ctrl_busy    (busy),
        .o_mul_ctrl_valid   (res_valid),
        .i_mul_ctrl_ready   (res_ready),
        .o_mul_ctrl_result  (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; junk is driven on the request inputs afterwards.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                         input bit push, input logic [31:0] ex);
        int n;
        n = 0;
        while (!dut_ready && n < 200) begin
            step();
            n++;
        end
        check("issue_ready", 32'(dut_ready), 32'd1);
        req_valid = 1'b1;
        src_a = a;
        src_b = b;
        ctrl = c;
        if (push) exp_q.push_back(ex);
        step();
        req_valid = 1'b0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h0BAD_F00D;
        ctrl = ~c;
    endtask

    // Count cycles from the accept edge (inclusive) until valid is seen.
    task automatic wait_valid(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!res_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            step();
            lat++;
        end
    endtask

    // Full-latency operation with immediate downstream acceptance.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] c, input logic [31:0] ex);
        int lat;
        bit bok;
        res_ready = 1'b1;
        issue(a, b, c, 1'b1, ex);
        wait_valid(lat, bok);
        check({name, "_latency"}, 32'(lat), 32'd34);
        check({name, "_busy_inflight"}, 32'(bok), 32'd1);
        check({name, "_busy_done_ready"}, 32'(busy), 32'd0);
        step();
    endtask

    // Scoreboard monitor: compare every result handed off downstream.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h, expected none", result);
            end else begin
                mon_exp = exp_q.pop_front();
                if (result !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got %h, expected %h", result, mon_exp);
                end
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit bok;
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        src_a = 32'd0;
        src_b = 32'd0;
        ctrl = 2'b00;
        flush = 1'b0;
        res_ready = 1'b0;
        step();
        step();
        check("rst_ready", 32'(dut_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        step();

        // MUL 7 x -3 with downstream stalled: busy through the valid cycle.
        res_ready = 1'b0;
        issue(32'd7, 32'hFFFF_FFFD, C_MUL, 1'b1, 32'hFFFF_FFEB);
        wait_valid(lat, bok);
        check("mul_latency", 32'(lat), 32'd34);
        check("mul_busy_inflight", 32'(bok), 32'd1);
        check("mul_busy_done_stalled", 32'(busy), 32'd1);
        res_ready = 1'b1;
        step();
        check("mul_idle_after_handoff", 32'(dut_ready), 32'd1);

        run_op("mulh_minneg", 32'h8000_0000, 32'h8000_0000, C_MULH, 32'h4000_0000);
        run_op("mulhu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, C_MULHU, 32'hFFFF_FFFE);
        run_op("mulhsu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, C_MULHSU, 32'hFFFF_FFFF);
        run_op("mul_minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, C_MUL, 32'h8000_0000);
        run_op("mulh_minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, C_MULH, 32'h0000_0000);

        // Zero fast path.
        res_ready = 1'b1;
        issue(32'd0, 32'h1234_5678, C_MULH, 1'b1, 32'd0);
        wait_valid(lat, bok);
        check("zero_latency", 32'(lat), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        step();

        // Backpressure: result held, new request refused.
        res_ready = 1'b0;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, C_MULHU, 1'b1, 32'hFFFF_FFFE);
        wait_valid(lat, bok);
        check("bp_latency", 32'(lat), 32'd34);
        req_valid = 1'b1;
        src_a = 32'd3;
        src_b = 32'd5;
        ctrl = C_MUL;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_result", result, 32'hFFFF_FFFE);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_ready", 32'(dut_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        req_valid = 1'b0;
        step();
        check("bp_release_ready", 32'(dut_ready), 32'd1);
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        step();
        check("bp_no_hidden_accept", 32'(busy), 32'd0);

        // Flush during CALC iteration 10.
        issue(32'd1234, 32'd5678, C_MUL, 1'b0, 32'd0);
        repeat (10) step();
        check("flush_calc_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_calc_valid", 32'(res_valid), 32'd0);
        check("flush_calc_busy", 32'(busy), 32'd0);
        check("flush_calc_ready", 32'(dut_ready), 32'd1);
        run_op("mul_3x5", 32'd3, 32'd5, C_MUL, 32'd15);

        // Flush in DONE drops the held result.
        res_ready = 1'b0;
        issue(32'd2, 32'd3, C_MUL, 1'b0, 32'd0);
        wait_valid(lat, bok);
        check("flush_done_latency", 32'(lat), 32'd34);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_done_valid", 32'(res_valid), 32'd0);
        check("flush_done_ready", 32'(dut_ready), 32'd1);
        res_ready = 1'b1;
        step();
        check("flush_done_no_result", 32'(res_valid), 32'd0);

        // Reset mid-CALC, with a request held during reset.
        issue(32'd5, 32'd6, C_MUL, 1'b0, 32'd0);
        repeat (5) step();
        rst = 1'b1;
        req_valid = 1'b1;
        src_a = 32'd9;
        src_b = 32'd9;
        ctrl = C_MUL;
        step();
        check("rst_mid_ready", 32'(dut_ready), 32'd1);
        check("rst_mid_valid", 32'(res_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", result, 32'd0);
        step();
        check("rst_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        step();
        check("rst_no_accept_busy", 32'(busy), 32'd0);
        check("rst_no_accept_ready", 32'(dut_ready), 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
